// File: rtl/packet_rx_assembler_pkg.sv
// Shared types and constants for the packet receive assembler.
//   WORD_W / BYTE_W / BYTES_PER_WORD : packing geometry (8 bytes per 64-bit word)
//   state_e                          : assembler FSM states
//   put_byte()                       : insert a byte into a little-endian word
package packet_rx_assembler_pkg;

    localparam int unsigned WORD_W         = 64;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 8;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPack    = 2'd1,
        StDiscard = 2'd2
    } state_e;

    // Byte k lands in bits [8k+7:8k].
    function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] word,
                                                   input logic [IDX_W-1:0]  idx,
                                                   input logic [BYTE_W-1:0] data);
        logic [WORD_W-1:0] res;
        res = word;
        res[idx*BYTE_W +: BYTE_W] = data;
        return res;
    endfunction

endpackage

// File: rtl/packet_rx_assembler_if.sv
// Byte-stream input, packet-word output and status bundle of the assembler.
//   slave  : assembler side (consumes bytes and pops, drives word/status outputs)
//   master : link/consumer side
interface packet_rx_assembler_if #(
    parameter int unsigned DROP_W = 16
) ();
    import packet_rx_assembler_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_start;
    logic              in_end;
    logic              out_pop;
    logic              out_nempty;
    logic [WORD_W-1:0] out_data;
    logic              out_end;
    logic [DROP_W-1:0] drop_count;
    logic              overflow;

    modport slave (
        input  in_valid, in_data, in_start, in_end, out_pop,
        output out_nempty, out_data, out_end, drop_count, overflow
    );

    modport master (
        output in_valid, in_data, in_start, in_end, out_pop,
        input  out_nempty, out_data, out_end, drop_count, overflow
    );

endinterface

// File: rtl/packet_rx_fifo.sv
// Packet FIFO with speculative write pointer and commit/rollback.
//   clk, rst_n      : clock, async active-low reset
//   push, push_data : write {end, data} at the (possibly rolled-back) write pointer
//   commit          : make everything written so far, including this push, visible
//   rollback        : discard uncommitted words (wr := commit) before this push
//   pop             : advance read pointer; ignored when empty
//   full            : speculative occupancy == depth
//   full_committed  : committed occupancy == depth (room seen after a rollback)
//   nempty, head    : committed word available / head entry (0 when empty)
module packet_rx_fifo
    import packet_rx_assembler_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [WORD_W:0] push_data,
    input  logic            commit,
    input  logic            rollback,
    input  logic            pop,
    output logic            full,
    output logic            full_committed,
    output logic            nempty,
    output logic [WORD_W:0] head
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    typedef logic [DEPTH_LOG2:0] ptr_t;
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    logic [WORD_W:0] mem [DEPTH];
    ptr_t wr_q, rd_q, cm_q;
    ptr_t wr_d, rd_d, cm_d, base;

    assign full           = (ptr_t'(wr_q - rd_q) == DEPTH_P);
    assign full_committed = (ptr_t'(cm_q - rd_q) == DEPTH_P);
    assign nempty         = (cm_q != rd_q);
    assign head           = nempty ? mem[rd_q[DEPTH_LOG2-1:0]] : '0;

    always_comb begin
        // A rollback and a push on the same edge write at the committed position.
        base = rollback ? cm_q : wr_q;
        wr_d = base + ptr_t'(push);
        cm_d = commit ? wr_d : cm_q;
        rd_d = rd_q + ptr_t'(pop && nempty);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[base[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            cm_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cm_q <= cm_d;
        end
    end

endmodule

// File: rtl/packet_rx_assembler.sv
// Packs a framed byte stream into 64-bit little-endian words and hands only
// complete packets to the consumer; packets that overflow or are aborted are
// dropped whole and counted.
//   clk, rst_n : clock, async active-low reset
//   bus        : byte input, popped word output, drop_count and sticky overflow
module packet_rx_assembler
    import packet_rx_assembler_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned DROP_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    packet_rx_assembler_if.slave  bus
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_eff;
    logic [WORD_W-1:0] acc_q, acc_d, new_acc;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W:0]   drop_sum;
    logic              ovf_q, ovf_d;
    logic [1:0]        drop_inc;

    logic            push, commit, rollback;
    logic            full, full_committed, nempty;
    logic [WORD_W:0] head;
    logic            accept, abort, word_done, room_full;

    packet_rx_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .push           (push),
        .push_data      ({bus.in_end, new_acc}),
        .commit         (commit),
        .rollback       (rollback),
        .pop            (bus.out_pop),
        .full           (full),
        .full_committed (full_committed),
        .nempty         (nempty),
        .head           (head)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        push     = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        drop_inc = 2'd0;

        abort     = bus.in_valid && bus.in_start && (state_q == StPack);
        accept    = bus.in_valid && (bus.in_start || (state_q == StPack));
        idx_eff   = bus.in_start ? '0 : idx_q;
        new_acc   = put_byte(bus.in_start ? '0 : acc_q, idx_eff, bus.in_data);
        word_done = accept && ((idx_eff == IDX_W'(BYTES_PER_WORD - 1)) || bus.in_end);
        // After an abort the uncommitted words are gone, so room is judged on
        // the committed occupancy.
        room_full = abort ? full_committed : full;

        if (abort) begin
            rollback = 1'b1;
            drop_inc = 2'd1;
        end

        if (accept) begin
            if (word_done) begin
                acc_d = '0;
                idx_d = '0;
                if (room_full) begin
                    rollback = 1'b1;
                    drop_inc = drop_inc + 2'd1;
                    ovf_d    = 1'b1;
                    state_d  = bus.in_end ? StIdle : StDiscard;
                end else begin
                    push = 1'b1;
                    if (bus.in_end) begin
                        commit  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StPack;
                    end
                end
            end else begin
                acc_d   = new_acc;
                idx_d   = idx_eff + IDX_W'(1);
                state_d = StPack;
            end
        end else if ((state_q == StDiscard) && bus.in_valid && bus.in_end) begin
            state_d = StIdle;
        end

        drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(drop_inc);
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            acc_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_nempty = nempty;
    assign bus.out_data   = head[WORD_W-1:0];
    assign bus.out_end    = head[WORD_W];
    assign bus.drop_count = drop_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_packet_rx_assembler.sv
// Self-checking bench: directed packets plus random byte/pop traffic, checked
// every cycle against a packet-level reference model.
module tb_packet_rx_assembler;

    localparam int unsigned DEPTH_LOG2 = 2;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam int unsigned DROP_W     = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    packet_rx_assembler_if #(.DROP_W(DROP_W)) bus ();

    packet_rx_assembler #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DROP_W     (DROP_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: committed words, bytes of the packet in flight.
    logic [64:0] mq[$];
    logic [7:0]  cur[$];
    int          cur_words;
    int          mst;          // 0 idle, 1 receiving, 2 discarding
    int unsigned m_drop;
    bit          m_ovf;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        cur.delete();
        cur_words = 0;
        mst = 0;
        m_drop = 0;
        m_ovf = 1'b0;
    endfunction

    function automatic void drop_one();
        if (m_drop < (1 << DROP_W) - 1) m_drop++;
    endfunction

    function automatic void commit_pkt();
        int n = cur.size();
        int nw = (n + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            logic [63:0] word = '0;
            for (int k = 0; k < 8; k++) begin
                if (w * 8 + k < n) word[8*k +: 8] = cur[w*8+k];
            end
            mq.push_back({(w == nw - 1), word});
        end
        cur.delete();
        cur_words = 0;
    endfunction

    function automatic void model_step(bit v, logic [7:0] d, bit s, bit e, bit p);
        int n_pre = mq.size();
        if (p && n_pre > 0) void'(mq.pop_front());
        if (!v) return;
        if (s) begin
            if (mst == 1) drop_one();
            cur.delete();
            cur_words = 0;
            cur.push_back(d);
            mst = 1;
        end else if (mst == 1) begin
            cur.push_back(d);
        end else begin
            if (mst == 2 && e) mst = 0;
            return;
        end
        if ((cur.size() % 8 == 0) || e) begin
            if (n_pre + cur_words == DEPTH) begin
                drop_one();
                m_ovf = 1'b1;
                mst = e ? 0 : 2;
                cur.delete();
                cur_words = 0;
            end else begin
                cur_words++;
                if (e) begin
                    commit_pkt();
                    mst = 0;
                end
            end
        end
    endfunction

    // One clock: check registered outputs against the model, drive, advance model.
    task automatic cyc(input bit v, input logic [7:0] d, input bit s, input bit e, input bit p);
        logic [64:0] exp_head;
        @(negedge clk);
        exp_head = (mq.size() > 0) ? mq[0] : 65'd0;
        chk("nempty", 65'(bus.out_nempty), 65'(mq.size() > 0));
        chk("head", {bus.out_end, bus.out_data}, exp_head);
        chk("drop_count", 65'(bus.drop_count), 65'(m_drop));
        chk("overflow", 65'(bus.overflow), 65'(m_ovf));
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_start = s;
        bus.in_end   = e;
        bus.out_pop  = p;
        model_step(v, d, s, e, p);
    endtask

    task automatic send(input int base, input int n, input bit with_end, input bit p);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 8'(base + i), (i == 0), with_end && (i == n - 1), p);
        end
    endtask

    task automatic idle(input int n, input bit p);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, p);
    endtask

    // Let the last driven edge complete before a directed look at the outputs.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        bus.in_end   = 1'b0;
        bus.out_pop  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_start = 1'b0;
        bus.in_end   = 1'b0;
        bus.out_pop  = 1'b0;
        model_reset();
        do_reset();
        chk("reset_nempty", 65'(bus.out_nempty), 65'd0);
        chk("reset_head", {bus.out_end, bus.out_data}, 65'd0);
        chk("reset_drop", 65'(bus.drop_count), 65'd0);
        idle(2, 1'b0);

        // 8-byte packet: one final word, visible right after the end byte.
        send(8'h01, 8, 1'b1, 1'b0);
        settle();
        chk("pkt8_nempty", 65'(bus.out_nempty), 65'd1);
        chk("pkt8_word", {bus.out_end, bus.out_data}, {1'b1, 64'h0807060504030201});
        idle(1, 1'b1);

        // 11-byte packet: nothing visible until the end byte.
        send(8'h10, 10, 1'b0, 1'b0);
        settle();
        chk("pkt11_hidden", 65'(bus.out_nempty), 65'd0);
        cyc(1'b1, 8'h1A, 1'b0, 1'b1, 1'b0);
        settle();
        chk("pkt11_w0", {bus.out_end, bus.out_data}, {1'b0, 64'h1716151413121110});
        idle(1, 1'b1);
        settle();
        chk("pkt11_w1", {bus.out_end, bus.out_data}, {1'b1, 64'h00000000001A1918});
        idle(1, 1'b1);

        // Single byte with start and end; stray byte without start ignored.
        cyc(1'b1, 8'hAB, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0);
        settle();
        chk("single_word", {bus.out_end, bus.out_data}, {1'b1, 64'h00000000000000AB});
        idle(1, 1'b1);
        settle();
        chk("stray_empty", 65'(bus.out_nempty), 65'd0);

        // Abort: 5 bytes, then a new start carrying a 3-byte packet.
        send(8'h20, 5, 1'b0, 1'b0);
        send(8'h30, 3, 1'b1, 1'b0);
        settle();
        chk("abort_word", {bus.out_end, bus.out_data}, {1'b1, 64'h0000000000323130});
        chk("abort_drop", 65'(bus.drop_count), 65'd1);
        chk("abort_ovf", 65'(bus.overflow), 65'd0);
        idle(2, 1'b1);

        // Overflow with a 4-deep FIFO: 3-word packet fits, next 2-word one does not.
        send(8'h40, 24, 1'b1, 1'b0);
        send(8'h80, 16, 1'b1, 1'b0);
        settle();
        chk("ovf_drop", 65'(bus.drop_count), 65'd2);
        chk("ovf_sticky", 65'(bus.overflow), 65'd1);
        chk("ovf_head", {bus.out_end, bus.out_data}, {1'b0, 64'h4746454443424140});
        idle(5, 1'b1);

        // Reset mid-packet, then a clean 2-byte packet, popped continuously.
        send(8'h50, 3, 1'b0, 1'b0);
        do_reset();
        send(8'h60, 2, 1'b1, 1'b0);
        settle();
        chk("rst_drop", 65'(bus.drop_count), 65'd0);
        chk("rst_word", {bus.out_end, bus.out_data}, {1'b1, 64'h0000000000006160});
        idle(2, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(3, 0) != 0), 8'($urandom),
                ($urandom_range(11, 0) == 0), ($urandom_range(9, 0) == 0),
                ($urandom_range(2, 0) == 0));
        end
        idle(12, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
